// File: rtl/click_arb_pkg.sv
// Shared types and the round-robin pick helper for click_channel_arbiter.
package click_arb_pkg;

  typedef enum logic [1:0] {IDLE, R_HI, L_LO, R_LO} arb_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;
  localparam int MAX_CH     = 16;
  localparam int PICK_W     = 4;

  typedef struct packed {
    logic              vld;
    logic [PICK_W-1:0] idx;
  } rr_pick_t;

  // First set bit at or above ptr, wrapping at n; ptr < n keeps ptr+k below 2n.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] req,
                                       input logic [PICK_W-1:0] ptr,
                                       input int n);
    rr_pick_t r;
    int j;
    r = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < n) begin
        j = int'(ptr) + k;
        if (j >= n) j = j - n;
        if (!r.vld && req[j]) begin
          r.vld = 1'b1;
          r.idx = PICK_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/click_sync2.sv
// Two-flop synchronizer, resets to 0. Used only when CLICK_ARB_SYNC_EN is defined.
module click_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [1:0][W-1:0] pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[0], d};
  end

  assign q = pipe[1];

endmodule

// File: rtl/click_channel_arbiter.sv
// Round-robin four-phase arbiter sharing one downstream click channel among N_CH requesters.
// Optional CLICK_ARB_SYNC_EN puts Lreq and Rack through 2-flop synchronizers.
module click_channel_arbiter
  import click_arb_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          Lreq,
  output logic [N_CH-1:0]          Lack,
  input  logic [N_CH*DATA_W-1:0]   Ldata,
  output logic                     Rreq,
  input  logic                     Rack,
  output logic [DATA_W-1:0]        Rdata,
  output logic [$clog2(N_CH)-1:0]  grant_idx,
  output logic                     busy,
  output logic [CNT_W-1:0]         xfer_cnt
);

  localparam int IDX_W = $clog2(N_CH);

  logic [N_CH-1:0] lreq_s;
  logic            rack_s;

`ifdef CLICK_ARB_SYNC_EN
  click_sync2 #(.W(N_CH + 1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({Rack, Lreq}),
    .q     ({rack_s, lreq_s})
  );
`else
  assign lreq_s = Lreq;
  assign rack_s = Rack;
`endif

  arb_state_e       st;
  logic [IDX_W-1:0] ptr;
  rr_pick_t         pick;
  logic [IDX_W-1:0] pick_idx;
  logic [DATA_W-1:0] pick_data;

  always_comb begin
    pick      = rr_pick(MAX_CH'(lreq_s), PICK_W'(ptr), N_CH);
    pick_idx  = IDX_W'(pick.idx);
    pick_data = Ldata[int'(pick_idx)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= IDLE;
      Lack      <= '0;
      Rreq      <= 1'b0;
      Rdata     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      xfer_cnt  <= '0;
    end else begin
      case (st)
        // A stray Rack still high from a previous cycle blocks any new grant.
        IDLE: if (!rack_s && pick.vld) begin
          Rdata     <= pick_data;
          grant_idx <= pick_idx;
          Rreq      <= 1'b1;
          st        <= R_HI;
        end
        R_HI: if (rack_s) begin
          Lack[grant_idx] <= 1'b1;
          st              <= L_LO;
        end
        L_LO: if (!lreq_s[grant_idx]) begin
          Rreq <= 1'b0;
          st   <= R_LO;
        end
        R_LO: if (!rack_s) begin
          Lack     <= '0;
          ptr      <= (grant_idx == IDX_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
          xfer_cnt <= xfer_cnt + 1'b1;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign busy = (st != IDLE);

endmodule

// File: doc/click_channel_arbiter.md
Name: click_channel_arbiter

Overview:
- Clocked four-phase arbiter that shares one downstream click channel (e.g. a subtractor-merge stage input) among N_CH upstream requesters.
- Each requester presents an Lreq/Lack/Ldata channel. The block grants one requester at a time in round-robin order.
- It forwards the granted requester's data on a single Rreq/Rack/Rdata channel and completes the full return-to-zero handshake on both sides before the next grant.

Parameters:
N_CH, 4, number of upstream requester channels (2..16)
DATA_W, 8, data width per channel
CNT_W, 16, width of the completed-transfer counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
Lreq  input  N_CH  per-channel request, four-phase
Lack  output  N_CH  per-channel acknowledge, registered
Ldata  input  N_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W]
Rreq  output  1  downstream request, registered
Rack  input  1  downstream acknowledge
Rdata  output  DATA_W  downstream data, registered
grant_idx  output  $clog2(N_CH)  index of the current/last granted channel
busy  output  1  high whenever FSM is not IDLE
xfer_cnt  output  CNT_W  completed transfers; wraps at 2^CNT_W

Behaviour:
- Reset (async assert, sync release): Lack=0, Rreq=0, Rdata=0, grant_idx=0, busy=0, xfer_cnt=0, rr pointer=0, FSM=IDLE. Assertion mid-transfer aborts immediately.
- "Seen" below means the sampled input: the raw input, or the synchronized input under SYNC_EN.
- FSM states and transitions:
  - IDLE: if Rack seen 0 and any Lreq seen 1, pick winner g = first set bit searching from pointer upward with wrap. Capture Rdata<=Ldata[g], set grant_idx<=g, go to R_HI. The next cycle shows Rreq=1 and busy=1. If Rack is seen 1 in IDLE (stray), no grant is made.
  - R_HI: Rreq=1. When Rack seen 1, go to L_LO with Lack[g]=1 next cycle.
  - L_LO: Lack[g]=1. When Lreq[g] seen 0, go to R_LO with Rreq=0 next cycle.
  - R_LO: Rreq=0, Lack[g] still 1. When Rack seen 0, go to IDLE: Lack[g]=0 next cycle, pointer<=(g+1) mod N_CH, xfer_cnt+=1.
- Latency (no SYNC_EN): Lreq rise at cycle t -> Rreq=1 at t+1. Each subsequent phase edge appears 1 cycle after the input edge that triggers it.
- Rdata is stable from the Rreq rise until the IDLE return. Only Lack[g] may ever be 1; all other Lack bits stay 0.
- Back-to-back: the earliest next grant is the IDLE cycle in which Lack[g] drops. A re-raised Lreq[g] competes with lowest priority.
- Lreq withdrawn before capture: not granted. A drop of Lreq[g] in R_HI is a protocol violation; it is not flagged, and L_LO exits on the first cycle.
- N_CH not a power of two: pointer wrap uses mod N_CH; grant_idx never exceeds N_CH-1.

Optional Feature:
- Macro CLICK_ARB_SYNC_EN.
- Defined: Lreq[*] and Rack each pass through a 2-flop synchronizer before use. Every input-to-output latency grows by 2 cycles (Lreq rise t -> Rreq rise t+3).
- Undefined: inputs are sampled directly and must be synchronous to clk.

Decomposition:
- Package click_arb_pkg:
  - state enum {IDLE, R_HI, L_LO, R_LO} (2-bit)
  - default DATA_W/CNT_W constants
  - function rr_pick(req vector, pointer) returning winner index and valid
- Sub-module click_sync2: 2-flop synchronizer, async active-low reset to 0, parameterized width. Instantiated only under CLICK_ARB_SYNC_EN.

Test Plan:
1. Single requester: Lreq[2]=1, Ldata[2]=8'h5A, downstream auto-acks in 1 cycle. Required: Rreq rises 1 cycle later with Rdata=8'h5A; Lack[2] follows Rack; full 4-phase completes; xfer_cnt=1; grant_idx=2.
2. Round-robin fairness: all four Lreq held high continuously, data = channel index + 8'h10. Required: grant order 0,1,2,3,0,1,…; Rdata sequence 8'h10,8'h11,8'h12,8'h13,8'h10; never two Lack bits high at once.
3. Slow downstream: Rack delayed 5 cycles on each edge. Required: Rreq and Rdata stable for the full wait; Lack[g] never rises before Rack; busy=1 throughout.
4. Stray Rack: Rack=1 while IDLE with Lreq[1]=1. Required: no Rreq until Rack returns to 0, then grant 1 on the next cycle.
5. Reset mid-transfer: assert rst_n=0 while in L_LO. Required: Lack, Rreq, Rdata, busy, xfer_cnt all 0 immediately; after release, the pending Lreq[0] is granted first.
6. CLICK_ARB_SYNC_EN build: repeat scenario 1. Required: Rreq rises 3 cycles after the Lreq rise; same data and ordering.
